eth_tx_frame_arbiter: RTL and testbench

Frame-atomic round-robin arbiter that shares the single `mini_mac` TX payload interface (ready/valid/data/eof byte stream) between several frame sources, e.g. the serial-protocol response engine and a status/heartbeat generator. It sits directly upstream of the MAC TX port.
- A source that wins keeps the grant until its frame's EOF beat is accepted.
- A length limit cuts off runaway frames.
- A programmable idle gap separates consecutive frames.

---
 rtl/eth_tx_frame_arbiter.sv | 155 +++++++++++++++
 tb/tb_eth_tx_frame_arbiter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/eth_tx_frame_arbiter.sv
// Frame-atomic round-robin arbiter sharing one MAC TX byte stream between NUM_SRC sources.
// Holds the grant until EOF, forces EOF at MAX_LEN, and inserts GAP_CYCLES idle cycles between frames.
module eth_tx_frame_arbiter #(
   parameter int NUM_SRC    = 2,
   parameter int MAX_LEN    = 1518,
   parameter int GAP_CYCLES = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NUM_SRC-1:0]     src_valid,
   input  logic [8*NUM_SRC-1:0]   src_data,
   input  logic [NUM_SRC-1:0]     src_eof,
   output logic [NUM_SRC-1:0]     src_ready,
   output logic                   tx_valid,
   output logic [7:0]             tx_data,
   output logic                   tx_eof,
   input  logic                   tx_ready,
   output logic [NUM_SRC-1:0]     grant,
   output logic                   truncated,
   output logic [15:0]            frame_count
);

   localparam int IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
   localparam int CW = $clog2(MAX_LEN + 1);
   localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

   typedef enum logic [1:0] {IDLE, PASS, DRAIN, GAP} state_t;

   localparam state_t AFTER_FRAME = (GAP_CYCLES == 0) ? IDLE : GAP;

   state_t              state;
   state_t              state_next;
   logic [IW-1:0]       owner;
   logic [IW-1:0]       last;
   logic [IW-1:0]       winner;
   logic                found;
   logic [NUM_SRC-1:0]  grant_q;
   logic [CW-1:0]       cnt;
   logic [GW-1:0]       gap_cnt;
   logic [15:0]         frame_cnt_q;
   logic                own_valid;
   logic                own_eof;
   logic [7:0]          own_data;
   logic                at_limit;
   logic                gap_done;
   logic                tx_beat;

   assign at_limit = (cnt == CW'(MAX_LEN - 1));
   assign gap_done = (gap_cnt == GW'(GAP_CYCLES - 1));
   assign tx_beat  = (state == PASS) && own_valid && tx_ready;

   // Search starts just after the previous winner so every requester gets a turn.
   always_comb begin
      int idx;
      idx    = 0;
      found  = 1'b0;
      winner = last;
      for (int k = 1; k <= NUM_SRC; k++) begin
         idx = (int'(last) + k) % NUM_SRC;
         if (!found && src_valid[idx]) begin
            found  = 1'b1;
            winner = IW'(idx);
         end
      end
   end

   always_comb begin
      own_valid = 1'b0;
      own_eof   = 1'b0;
      own_data  = 8'h00;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (owner == IW'(i)) begin
            own_valid = src_valid[i];
            own_eof   = src_eof[i];
            own_data  = src_data[8*i +: 8];
         end
      end
   end

   always_comb begin
      state_next = state;
      src_ready  = '0;
      tx_valid   = 1'b0;
      tx_data    = 8'h00;
      tx_eof     = 1'b0;
      truncated  = 1'b0;
      case (state)
         IDLE: begin
            if (found) state_next = PASS;
         end
         PASS: begin
            tx_valid  = own_valid;
            tx_data   = own_data;
            tx_eof    = own_eof | at_limit;
            src_ready = grant_q & {NUM_SRC{tx_ready}};
            if (own_valid && tx_ready && (own_eof || at_limit)) begin
               if (!own_eof) begin
                  truncated  = 1'b1;
                  state_next = DRAIN;
               end else begin
                  state_next = AFTER_FRAME;
               end
            end
         end
         DRAIN: begin
            src_ready = grant_q;
            if (own_valid && own_eof) state_next = AFTER_FRAME;
         end
         GAP: begin
            if (gap_done) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
      // A synchronous reset still silences the MAC immediately, mid-frame included.
      if (reset) begin
         src_ready = '0;
         tx_valid  = 1'b0;
         tx_data   = 8'h00;
         tx_eof    = 1'b0;
         truncated = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         grant_q     <= '0;
         owner       <= '0;
         last        <= IW'(NUM_SRC - 1);
         cnt         <= '0;
         gap_cnt     <= '0;
         frame_cnt_q <= 16'h0000;
      end else begin
         state <= state_next;
         if (state == IDLE && found) begin
            grant_q <= {{(NUM_SRC-1){1'b0}}, 1'b1} << winner;
            owner   <= winner;
            last    <= winner;
            cnt     <= '0;
         end else if (state_next == GAP || state_next == IDLE) begin
            grant_q <= '0;
         end
         if (tx_beat) begin
            if (cnt != CW'(MAX_LEN)) cnt <= cnt + 1'b1;
            if (own_eof || at_limit) frame_cnt_q <= frame_cnt_q + 16'h0001;
         end
         if (state == GAP) gap_cnt <= gap_cnt + 1'b1;
         else              gap_cnt <= '0;
      end
   end

   assign grant       = reset ? '0 : grant_q;
   assign frame_count = reset ? 16'h0000 : frame_cnt_q;

endmodule

// File: tb/tb_eth_tx_frame_arbiter.sv
// Directed bench for eth_tx_frame_arbiter with NUM_SRC=3, MAX_LEN=4, GAP_CYCLES=2.
// Expected values per cycle are written by hand from the arbiter's frame/gap timing.
module tb_eth_tx_frame_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  src_valid;
   logic [23:0] src_data;
   logic [2:0]  src_eof;
   logic [2:0]  src_ready;
   logic        tx_valid;
   logic [7:0]  tx_data;
   logic        tx_eof;
   logic        tx_ready;
   logic [2:0]  grant;
   logic        truncated;
   logic [15:0] frame_count;

   int checks     = 0;
   int failures   = 0;
   int exp_frames = 0;

   always #5 clk = ~clk;

   eth_tx_frame_arbiter #(
      .NUM_SRC    (3),
      .MAX_LEN    (4),
      .GAP_CYCLES (2)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .src_valid   (src_valid),
      .src_data    (src_data),
      .src_eof     (src_eof),
      .src_ready   (src_ready),
      .tx_valid    (tx_valid),
      .tx_data     (tx_data),
      .tx_eof      (tx_eof),
      .tx_ready    (tx_ready),
      .grant       (grant),
      .truncated   (truncated),
      .frame_count (frame_count)
   );

   function automatic logic [23:0] onSrc(input int s, input logic [7:0] b);
      return 24'(b) << (8 * s);
   endfunction

   task automatic applyStimulus(input logic rst, input logic [2:0] v, input logic [23:0] d,
                                input logic [2:0] e, input logic r);
      reset     = rst;
      src_valid = v;
      src_data  = d;
      src_eof   = e;
      tx_ready  = r;
      #1;
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   task automatic checkBus(input string tag, input logic [2:0] g, input logic v, input logic [7:0] d,
                           input logic e, input logic [2:0] rdy, input logic tr);
      checkOutput({tag, ".grant"}, 32'(grant), 32'(g));
      checkOutput({tag, ".tx_valid"}, 32'(tx_valid), 32'(v));
      if (v) begin
         checkOutput({tag, ".tx_data"}, 32'(tx_data), 32'(d));
         checkOutput({tag, ".tx_eof"}, 32'(tx_eof), 32'(e));
      end
      checkOutput({tag, ".src_ready"}, 32'(src_ready), 32'(rdy));
      checkOutput({tag, ".truncated"}, 32'(truncated), 32'(tr));
      checkOutput({tag, ".frame_count"}, 32'(frame_count), 32'(exp_frames));
   endtask

   initial begin
      logic       rdy_pat [5];
      int         byte_pat [5];
      logic [23:0] base;
      int         o;

      rdy_pat  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      byte_pat = '{0, 1, 1, 2, 2};
      base     = 24'h302010;

      applyStimulus(1'b1, 3'b000, 24'h0, 3'b000, 1'b1);
      checkBus("rst0", 3'b000, 1'b0, 8'h00, 1'b0, 3'b000, 1'b0);
      nextCycle();
      applyStimulus(1'b1, 3'b000, 24'h0, 3'b000, 1'b1);
      checkBus("rst1", 3'b000, 1'b0, 8'h00, 1'b0, 3'b000, 1'b0);
      nextCycle();
      applyStimulus(1'b0, 3'b000, 24'h0, 3'b000, 1'b1);
      checkBus("post_rst", 3'b000, 1'b0, 8'h00, 1'b0, 3'b000, 1'b0);
      nextCycle();

      // Four-byte frame from src0; byte 4 hits MAX_LEN together with the natural EOF.
      applyStimulus(1'b0, 3'b001, onSrc(0, 8'hA1), 3'b000, 1'b1);
      checkBus("t1.arb", 3'b000, 1'b0, 8'h00, 1'b0, 3'b000, 1'b0);
      nextCycle();
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b0, 3'b001, onSrc(0, 8'(8'hA1 + i)), (i == 3) ? 3'b001 : 3'b000, 1'b1);
         checkBus($sformatf("t1.b%0d", i), 3'b001, 1'b1, 8'(8'hA1 + i), (i == 3), 3'b001, 1'b0);
         nextCycle();
      end
      exp_frames = 1;
      for (int i = 0; i < 2; i++) begin
         applyStimulus(1'b0, 3'b000, 24'h0, 3'b000, 1'b1);
         checkBus($sformatf("t1.gap%0d", i), 3'b000, 1'b0, 8'h00, 1'b0, 3'b000, 1'b0);
         nextCycle();
      end

      // Back-pressure on a three-byte frame from src2.
      applyStimulus(1'b0, 3'b100, onSrc(2, 8'hB1), 3'b000, 1'b1);
      checkBus("t2.arb", 3'b000, 1'b0, 8'h00, 1'b0, 3'b000, 1'b0);
      nextCycle();
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b0, 3'b100, onSrc(2, 8'(8'hB1 + byte_pat[i])),
                       (byte_pat[i] == 2) ? 3'b100 : 3'b000, rdy_pat[i]);
         checkBus($sformatf("t2.c%0d", i), 3'b100, 1'b1, 8'(8'hB1 + byte_pat[i]), (byte_pat[i] == 2),
                  rdy_pat[i] ? 3'b100 : 3'b000, 1'b0);
         nextCycle();
      end
      exp_frames = 2;
      for (int i = 0; i < 2; i++) begin
         applyStimulus(1'b0, 3'b000, 24'h0, 3'b000, 1'b1);
         checkBus($sformatf("t2.gap%0d", i), 3'b000, 1'b0, 8'h00, 1'b0, 3'b000, 1'b0);
         nextCycle();
      end

      // Six-byte frame from src1 is cut at byte 4, the rest drained.
      applyStimulus(1'b0, 3'b010, onSrc(1, 8'hC1), 3'b000, 1'b1);
      checkBus("t3.arb", 3'b000, 1'b0, 8'h00, 1'b0, 3'b000, 1'b0);
      nextCycle();
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b0, 3'b010, onSrc(1, 8'(8'hC1 + i)), 3'b000, 1'b1);
         checkBus($sformatf("t3.b%0d", i), 3'b010, 1'b1, 8'(8'hC1 + i), (i == 3), 3'b010, (i == 3));
         nextCycle();
      end
      exp_frames = 3;
      applyStimulus(1'b0, 3'b010, onSrc(1, 8'hC5), 3'b000, 1'b0);
      checkBus("t3.drain5", 3'b010, 1'b0, 8'h00, 1'b0, 3'b010, 1'b0);
      nextCycle();
      applyStimulus(1'b0, 3'b010, onSrc(1, 8'hC6), 3'b010, 1'b1);
      checkBus("t3.drain6", 3'b010, 1'b0, 8'h00, 1'b0, 3'b010, 1'b0);
      nextCycle();
      for (int i = 0; i < 2; i++) begin
         applyStimulus(1'b0, 3'b000, 24'h0, 3'b000, 1'b1);
         checkBus($sformatf("t3.gap%0d", i), 3'b000, 1'b0, 8'h00, 1'b0, 3'b000, 1'b0);
         nextCycle();
      end

      // Reset lands on byte 2 of a src0 frame.
      applyStimulus(1'b0, 3'b001, onSrc(0, 8'hD1), 3'b000, 1'b1);
      checkBus("t4.arb", 3'b000, 1'b0, 8'h00, 1'b0, 3'b000, 1'b0);
      nextCycle();
      applyStimulus(1'b0, 3'b001, onSrc(0, 8'hD1), 3'b000, 1'b1);
      checkBus("t4.b0", 3'b001, 1'b1, 8'hD1, 1'b0, 3'b001, 1'b0);
      nextCycle();
      exp_frames = 0;
      applyStimulus(1'b1, 3'b001, onSrc(0, 8'hD2), 3'b000, 1'b1);
      checkBus("t4.rst", 3'b000, 1'b0, 8'h00, 1'b0, 3'b000, 1'b0);
      nextCycle();

      // All three sources request two-byte frames continuously; src0 must win first after reset.
      for (int f = 0; f < 6; f++) begin
         o = f % 3;
         applyStimulus(1'b0, 3'b111, base, 3'b000, 1'b1);
         checkBus($sformatf("rr%0d.idle", f), 3'b000, 1'b0, 8'h00, 1'b0, 3'b000, 1'b0);
         nextCycle();
         applyStimulus(1'b0, 3'b111, base, 3'b000, 1'b1);
         checkBus($sformatf("rr%0d.b0", f), 3'(1 << o), 1'b1, 8'((o + 1) << 4), 1'b0, 3'(1 << o), 1'b0);
         nextCycle();
         applyStimulus(1'b0, 3'b111, base | onSrc(o, 8'h01), 3'(1 << o), 1'b1);
         checkBus($sformatf("rr%0d.b1", f), 3'(1 << o), 1'b1, 8'(((o + 1) << 4) | 1), 1'b1, 3'(1 << o), 1'b0);
         nextCycle();
         exp_frames++;
         for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 3'b111, base, 3'b000, 1'b1);
            checkBus($sformatf("rr%0d.gap%0d", f, i), 3'b000, 1'b0, 8'h00, 1'b0, 3'b000, 1'b0);
            nextCycle();
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
